instruction_fetch: RTL and testbench

//  Fetch stage directly downstream of the instruction cache. Holds the PC and issues word-address

---
 rtl/instruction_fetch_pkg.sv | 24 ++
 rtl/instruction_fetch_if.sv | 24 ++
 rtl/instruction_fetch_line_buffer.sv | 46 ++++
 rtl/instruction_fetch.sv | 119 +++++++++++
 tb/tb_instruction_fetch.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, line geometry and
// small helpers used by the top and the line buffer.
package fetch_pkg;

   typedef enum logic [0:0] {
      S_FETCH     = 1'b0,
      S_MISS_WAIT = 1'b1
   } fetch_state_t;

   localparam int LINE_WORDS = 4;
   localparam int WORD_SEL_W = $clog2(LINE_WORDS);

   // Bit position of the selected word inside a packed cache line
   function automatic int unsigned word_lsb(input logic [WORD_SEL_W-1:0] sel,
                                            input int unsigned width);
      return width * sel;
   endfunction

   // Event counter that sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Request/response bus between the fetch stage (master) and the
// instruction cache (slave). Names are from the fetch stage's viewpoint.
interface instruction_fetch_if
   import fetch_pkg::*;
#(
   parameter int ADDR_W     = 22,
   parameter int DATA_WIDTH = 32
);
   logic                           o_IC_Valid;
   logic [ADDR_W-1:0]              o_IC_Address;
   logic                           i_IC_Ready;
   logic                           i_IC_Valid;
   logic [LINE_WORDS*DATA_WIDTH-1:0] i_IC_Data;

   modport master (
      output o_IC_Valid, o_IC_Address,
      input  i_IC_Ready, i_IC_Valid, i_IC_Data
   );

   modport slave (
      input  o_IC_Valid, o_IC_Address,
      output i_IC_Ready, i_IC_Valid, i_IC_Data
   );
endinterface

// File: rtl/instruction_fetch_line_buffer.sv
// One-line buffer holding the most recently filled cache line. Provides the
// line-match compare and the word mux for both the buffered line and the
// line arriving from the cache this cycle.
module fetch_line_buffer
   import fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LINE_TAG_W = 28
) (
   input  logic                             i_Clk,
   input  logic                             i_Reset_n,
   input  logic                             i_Load,
   input  logic [LINE_TAG_W-1:0]            i_Line,
   input  logic [WORD_SEL_W-1:0]            i_Word_Sel,
   input  logic [LINE_WORDS*DATA_WIDTH-1:0] i_Fill_Data,
   output logic                             o_Hit,
   output logic [DATA_WIDTH-1:0]            o_Word,
   output logic [DATA_WIDTH-1:0]            o_Fill_Word
);

   logic                             r_LB_Valid;
   logic [LINE_TAG_W-1:0]            r_LB_Line;
   logic [LINE_WORDS*DATA_WIDTH-1:0] r_LB_Data;

   // Validity is control state and is cleared by reset
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) r_LB_Valid <= 1'b0;
      else if (i_Load) r_LB_Valid <= 1'b1;
   end

   // Line tag and data are only meaningful while r_LB_Valid is set
   always_ff @(posedge i_Clk) begin
      if (i_Load) begin
         r_LB_Line <= i_Line;
         r_LB_Data <= i_Fill_Data;
      end
   end

   // Match compare and word selection for buffered and incoming lines
   always_comb begin
      o_Hit       = r_LB_Valid && (r_LB_Line == i_Line);
      o_Word      = r_LB_Data[word_lsb(i_Word_Sel, DATA_WIDTH) +: DATA_WIDTH];
      o_Fill_Word = i_Fill_Data[word_lsb(i_Word_Sel, DATA_WIDTH) +: DATA_WIDTH];
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, serves sequential words from a one-line buffer,
// requests the cache on buffer misses and waits out cache misses.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int          TAG_WIDTH          = 14,
   parameter int          INDEX_WIDTH        = 5,
   parameter int          BLOCK_OFFSET_WIDTH = 2,
   parameter int          DATA_WIDTH         = 32,
   parameter logic [31:0] RESET_PC           = 32'h0
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset_n,
   instruction_fetch_if.master   ic,
   input  logic                  i_Stall,
   input  logic                  i_Branch_Valid,
   input  logic [31:0]           i_Branch_Target,
   output logic                  o_Valid,
   output logic [DATA_WIDTH-1:0] o_Instruction,
   output logic [31:0]           o_PC,
   output logic [15:0]           o_Miss_Count
);

   localparam int ADDR_W     = TAG_WIDTH + INDEX_WIDTH + BLOCK_OFFSET_WIDTH + 1;
   localparam int LINE_TAG_W = 32 - BLOCK_OFFSET_WIDTH - 2;

   fetch_state_t          r_State, w_Next_State;
   logic [31:0]           r_PC;
   logic                  r_Valid;
   logic [DATA_WIDTH-1:0] r_Instruction;
   logic [31:0]           r_Out_PC;
   logic [15:0]           r_Miss_Count;

   logic                  w_Accept;
   logic                  w_Request;
   logic                  w_Fill;
   logic                  w_Miss;
   logic                  w_LB_Hit;
   logic [DATA_WIDTH-1:0] w_LB_Word;
   logic [DATA_WIDTH-1:0] w_Fill_Word;

   assign w_Accept = !r_Valid || !i_Stall;

   fetch_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .LINE_TAG_W (LINE_TAG_W)
   ) u_line_buffer (
      .i_Clk       (i_Clk),
      .i_Reset_n   (i_Reset_n),
      .i_Load      (w_Fill),
      .i_Line      (r_PC[31:32-LINE_TAG_W]),
      .i_Word_Sel  (r_PC[BLOCK_OFFSET_WIDTH+1:2]),
      .i_Fill_Data (ic.i_IC_Data),
      .o_Hit       (w_LB_Hit),
      .o_Word      (w_LB_Word),
      .o_Fill_Word (w_Fill_Word)
   );

   // FSM state register
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) r_State <= S_FETCH;
      else            r_State <= w_Next_State;
   end

   // Next state: a cache miss parks the FSM until the cache is ready again;
   // a branch never aborts that wait, it only retargets the PC
   always_comb begin
      w_Next_State = r_State;
      case (r_State)
         S_FETCH:     if (w_Miss)         w_Next_State = S_MISS_WAIT;
         S_MISS_WAIT: if (ic.i_IC_Ready)  w_Next_State = S_FETCH;
         default:                         w_Next_State = S_FETCH;
      endcase
   end

   // Cache request only when decode can take a word, no redirect is pending
   // and the buffered line does not already cover the PC
   always_comb begin
      w_Request = (r_State == S_FETCH) && w_Accept && !i_Branch_Valid &&
                  !w_LB_Hit && ic.i_IC_Ready;
      w_Fill    = w_Request && ic.i_IC_Valid;
      w_Miss    = w_Request && !ic.i_IC_Valid;
   end

   assign ic.o_IC_Valid   = w_Request;
   assign ic.o_IC_Address = r_PC[ADDR_W+1:2];

   // PC and decode-facing output registers; branch overrides everything
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_PC          <= RESET_PC;
         r_Valid       <= 1'b0;
         r_Instruction <= '0;
         r_Out_PC      <= 32'h0;
         r_Miss_Count  <= 16'h0;
      end else if (i_Branch_Valid) begin
         r_PC    <= i_Branch_Target & ~32'd3;
         r_Valid <= 1'b0;
      end else if (r_State == S_MISS_WAIT) begin
         r_Valid <= 1'b0;
      end else if (w_Accept) begin
         if (w_LB_Hit || w_Fill) begin
            r_Instruction <= w_LB_Hit ? w_LB_Word : w_Fill_Word;
            r_Out_PC      <= r_PC;
            r_Valid       <= 1'b1;
            r_PC          <= r_PC + 32'd4;
         end else begin
            r_Valid <= 1'b0;
            if (w_Miss) r_Miss_Count <= sat_inc16(r_Miss_Count);
         end
      end
   end

   assign o_Valid       = r_Valid;
   assign o_Instruction = r_Instruction;
   assign o_PC          = r_Out_PC;
   assign o_Miss_Count  = r_Miss_Count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations
// plus a per-cycle behavioural model of the fetch rules.
module tb_instruction_fetch;
   import fetch_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        stall, br, rdy, hit;
   logic [31:0] tgt;

   logic        o_Valid;
   logic [31:0] o_Instruction;
   logic [31:0] o_PC;
   logic [15:0] o_Miss_Count;

   int n_checks = 0;
   int n_fail   = 0;
   int ic_pulses = 0;
   int pulse_mark;
   bit seen_40 = 0;

   instruction_fetch_if ic_bus ();

   // Memory image: word at word-address wa holds wa+1
   function automatic logic [31:0] mem_word(input logic [21:0] wa);
      return {10'b0, wa} + 32'd1;
   endfunction

   function automatic logic [127:0] line_of(input logic [21:0] wa);
      logic [127:0] l;
      for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word({wa[21:2], 2'(k)});
      return l;
   endfunction

   assign ic_bus.i_IC_Ready = rdy;
   assign ic_bus.i_IC_Valid = hit;
   assign ic_bus.i_IC_Data  = line_of(ic_bus.o_IC_Address);

   instruction_fetch #(.RESET_PC(32'h0)) dut (
      .i_Clk           (clk),
      .i_Reset_n       (rst_n),
      .ic              (ic_bus),
      .i_Stall         (stall),
      .i_Branch_Valid  (br),
      .i_Branch_Target (tgt),
      .o_Valid         (o_Valid),
      .o_Instruction   (o_Instruction),
      .o_PC            (o_PC),
      .o_Miss_Count    (o_Miss_Count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc, m_opc, m_oinstr;
   logic        m_ov, m_wait, m_lbv;
   logic [27:0] m_lb_line;
   logic [15:0] m_miss;

   function automatic logic [31:0] pc_word(input logic [31:0] pc);
      return mem_word(pc[23:2]);
   endfunction

   function automatic bit m_lb_covers();
      return m_lbv && (m_lb_line == m_pc[31:4]);
   endfunction

   // Model advances on the same edge as the DUT, using only bench inputs
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc <= 32'h0; m_ov <= 1'b0; m_opc <= 32'h0; m_oinstr <= 32'h0;
         m_lbv <= 1'b0; m_lb_line <= 28'h0; m_wait <= 1'b0; m_miss <= 16'h0;
      end else if (m_wait) begin
         m_ov <= 1'b0;
         if (rdy) m_wait <= 1'b0;
         if (br)  m_pc <= {tgt[31:2], 2'b00};
      end else if (br) begin
         m_pc <= {tgt[31:2], 2'b00};
         m_ov <= 1'b0;
      end else if (!m_ov || !stall) begin
         if (m_lb_covers() || (rdy && hit)) begin
            m_ov <= 1'b1; m_opc <= m_pc; m_oinstr <= pc_word(m_pc); m_pc <= m_pc + 32'd4;
            if (!m_lb_covers()) begin m_lbv <= 1'b1; m_lb_line <= m_pc[31:4]; end
         end else begin
            m_ov <= 1'b0;
            if (rdy) begin
               m_wait <= 1'b1;
               m_miss <= (m_miss == 16'hFFFF) ? m_miss : m_miss + 16'd1;
            end
         end
      end
   end

   // Compare DUT against the model on every falling edge out of reset
   always @(negedge clk) begin
      if (rst_n) begin
         check("mdl_valid", {31'b0, o_Valid}, {31'b0, m_ov});
         check("mdl_miss", {16'b0, o_Miss_Count}, {16'b0, m_miss});
         check("mdl_icaddr", {10'b0, ic_bus.o_IC_Address}, {10'b0, m_pc[23:2]});
         check("mdl_icvalid", {31'b0, ic_bus.o_IC_Valid},
               {31'b0, (!m_wait && !br && (!m_ov || !stall) && !m_lb_covers() && rdy)});
         if (m_ov) begin
            check("mdl_pc", o_PC, m_opc);
            check("mdl_instr", o_Instruction, m_oinstr);
         end
         if (ic_bus.o_IC_Valid) ic_pulses++;
         if (o_Valid && o_PC == 32'h40) seen_40 = 1;
      end
   end

   // ---------------- directed scenarios ----------------
   initial begin
      rst_n = 1'b0; stall = 1'b0; br = 1'b0; tgt = 32'h0; rdy = 1'b1; hit = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'b0, o_Valid}, 32'h0);
      check("rst_pc", o_PC, 32'h0);
      check("rst_miss", {16'b0, o_Miss_Count}, 32'h0);
      check("rst_icaddr", {10'b0, ic_bus.o_IC_Address}, 32'h0);

      // 1: line {4,3,2,1} served over four cycles from a single request
      rst_n = 1'b1;
      pulse_mark = ic_pulses;
      #1 check("t1_req", {31'b0, ic_bus.o_IC_Valid}, 32'h1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("t1_valid", {31'b0, o_Valid}, 32'h1);
         check("t1_pc", o_PC, 32'(4 * i));
         check("t1_instr", o_Instruction, 32'(i + 1));
      end
      check("t1_pulses", 32'(ic_pulses - pulse_mark), 32'h1);

      // 2: miss at 0x10, cache busy for six cycles
      hit = 1'b0;
      step();
      check("t2_valid", {31'b0, o_Valid}, 32'h0);
      check("t2_miss", {16'b0, o_Miss_Count}, 32'h1);
      rdy = 1'b0; hit = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("t2_wait_valid", {31'b0, o_Valid}, 32'h0);
         check("t2_wait_req", {31'b0, ic_bus.o_IC_Valid}, 32'h0);
      end
      rdy = 1'b1;
      #1 check("t2_no_req_in_wait", {31'b0, ic_bus.o_IC_Valid}, 32'h0);
      step();
      check("t2_back_valid", {31'b0, o_Valid}, 32'h0);
      check("t2_rereq", {31'b0, ic_bus.o_IC_Valid}, 32'h1);
      check("t2_rereq_addr", {10'b0, ic_bus.o_IC_Address}, 32'h4);
      step();
      check("t2_pc", o_PC, 32'h10);
      check("t2_instr", o_Instruction, 32'h5);

      // 3: stall holds outputs at PC 4 (target low bits ignored)
      br = 1'b1; tgt = 32'h6;
      step();
      br = 1'b0;
      check("t3_br_valid", {31'b0, o_Valid}, 32'h0);
      step();
      check("t3_pc", o_PC, 32'h4);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("t3_stall_req", {31'b0, ic_bus.o_IC_Valid}, 32'h0);
         step();
         check("t3_hold_valid", {31'b0, o_Valid}, 32'h1);
         check("t3_hold_pc", o_PC, 32'h4);
         check("t3_hold_instr", o_Instruction, 32'h2);
      end
      stall = 1'b0;
      step();
      check("t3_release_pc", o_PC, 32'h8);

      // 4: branch to 0x108 while stalled
      stall = 1'b1; br = 1'b1; tgt = 32'h108;
      step();
      check("t4_valid", {31'b0, o_Valid}, 32'h0);
      br = 1'b0; stall = 1'b0;
      #1 check("t4_req_addr", {10'b0, ic_bus.o_IC_Address}, 32'h42);
      step();
      check("t4_pc", o_PC, 32'h108);
      check("t4_instr", o_Instruction, 32'h43);

      // 5: branch to 0x200 during the miss wait for 0x40
      hit = 1'b0; br = 1'b1; tgt = 32'h40;
      step();
      br = 1'b0;
      step();
      check("t5_miss", {16'b0, o_Miss_Count}, 32'h2);
      rdy = 1'b0; br = 1'b1; tgt = 32'h200;
      step();
      br = 1'b0;
      repeat (2) step();
      check("t5_wait_valid", {31'b0, o_Valid}, 32'h0);
      rdy = 1'b1; hit = 1'b1;
      step();
      check("t5_req", {31'b0, ic_bus.o_IC_Valid}, 32'h1);
      check("t5_addr", {10'b0, ic_bus.o_IC_Address}, 32'h80);
      step();
      check("t5_pc", o_PC, 32'h200);
      check("t5_instr", o_Instruction, 32'h81);

      // PC wrap across 2^32
      br = 1'b1; tgt = 32'hFFFF_FFFC;
      step();
      br = 1'b0;
      step();
      check("wrap_pc_hi", o_PC, 32'hFFFF_FFFC);
      check("wrap_instr_hi", o_Instruction, 32'h0040_0000);
      step();
      check("wrap_pc_lo", o_PC, 32'h0);
      check("wrap_instr_lo", o_Instruction, 32'h1);

      // 6: reset in the middle of a miss wait
      hit = 1'b0; br = 1'b1; tgt = 32'h300;
      step();
      br = 1'b0;
      step();
      check("t6_miss", {16'b0, o_Miss_Count}, 32'h3);
      rdy = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check("t6_valid", {31'b0, o_Valid}, 32'h0);
      check("t6_miss_clr", {16'b0, o_Miss_Count}, 32'h0);
      check("t6_addr", {10'b0, ic_bus.o_IC_Address}, 32'h0);
      rdy = 1'b1; hit = 1'b1;
      step();
      rst_n = 1'b1;
      #1 check("t6_req", {31'b0, ic_bus.o_IC_Valid}, 32'h1);
      step();
      check("t6_pc", o_PC, 32'h0);
      check("t6_instr", o_Instruction, 32'h1);

      check("never_pc_40", {31'b0, seen_40}, 32'h0);
      repeat (2) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
